// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encoding, opcode
// upper-nibble constants, the ALU no-op opcode and status-register bit indices.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_LO,
    ST_WAIT_LO,
    ST_CAP_LO,
    ST_ISSUE_HI,
    ST_WAIT_HI,
    ST_CAP_HI,
    ST_DONE
  } state_e;

  // Operation class lives in the upper nibble of the opcode.
  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_MULT = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADDC = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_SUBC = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_DEC  = 4'h9;
  localparam logic [3:0] OP_NEG  = 4'hA;

  // Full opcode that makes the ALU hold its result and flags.
  localparam logic [7:0] OP_NOP = 8'hFF;

  // Bit positions inside sreg = {n, z, c}.
  localparam int SREG_N = 2;
  localparam int SREG_Z = 1;
  localparam int SREG_C = 0;

endpackage

// File: rtl/alu_ctrl_opmap.sv
// Combinational opcode decode for 16-bit chaining: produces the opcode used
// for the high byte and flags whether the op class may be chained at all.
module alu_ctrl_opmap
  import alu_ctrl_pkg::*;
(
  input  logic [7:0] opcode_i,
  output logic [7:0] hi_opcode_o,
  output logic       wide_ok_o
);

  // Arithmetic ops switch to their carry-in form for the upper byte;
  // bitwise and already-carried ops are reused unchanged.
  always_comb begin
    hi_opcode_o = opcode_i;
    wide_ok_o   = 1'b0;
    case (opcode_i[7:4])
      OP_ADD:  hi_opcode_o = {OP_ADDC, opcode_i[3:0]};
      OP_SUB:  hi_opcode_o = {OP_SUBC, opcode_i[3:0]};
      default: hi_opcode_o = opcode_i;
    endcase
    case (opcode_i[7:4])
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: wide_ok_o = 1'b1;
      default: wide_ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Sequencer that issues one request to an external pipelined ALU, waits out
// its latency, captures result and flags, and emits a one-cycle writeback.
// Define ALU_CTRL_WIDE_EN to enable 16-bit chained (two-pass) operations;
// without it every request executes as a single 8-bit pass.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 2,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_opcode,
  input  logic [7:0]        req_a,
  input  logic [7:0]        req_b,
  input  logic [7:0]        req_a_hi,
  input  logic [7:0]        req_b_hi,
  input  logic              req_wide,
  input  logic [REG_AW-1:0] req_rd,
  output logic [7:0]        alu_opcode,
  output logic [7:0]        alu_rd,
  output logic [7:0]        alu_rr,
  output logic              alu_ci,
  input  logic [15:0]       alu_data,
  input  logic              alu_co,
  input  logic              alu_zo,
  input  logic              alu_no,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [15:0]       wb_data,
  output logic [2:0]        sreg
);

  // WAIT spans ALU_LAT-1 cycles; with a single-cycle ALU it is skipped.
  localparam int              CNT_W     = (ALU_LAT > 2) ? $clog2(ALU_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((ALU_LAT >= 2) ? (ALU_LAT - 2) : 0);
  localparam bit              SKIP_WAIT = (ALU_LAT < 2);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mult_q;
  logic [REG_AW-1:0]   rd_q;
  logic [7:0]          alu_opcode_q;
  logic [7:0]          alu_rd_q;
  logic [7:0]          alu_rr_q;
  logic                alu_ci_q;
  logic                wb_valid_q;
  logic [REG_AW-1:0]   wb_addr_q;
  logic [15:0]         wb_data_q;
  logic [2:0]          sreg_q;
  logic                accept;

`ifdef ALU_CTRL_WIDE_EN
  logic [7:0] hi_op_d;
  logic       wide_ok;
  logic       wide_q;
  logic [7:0] hi_op_q;
  logic [7:0] a_hi_q;
  logic [7:0] b_hi_q;
  logic [7:0] lo_q;
  logic       lo_z_q;

  alu_ctrl_opmap u_opmap (
    .opcode_i    (req_opcode),
    .hi_opcode_o (hi_op_d),
    .wide_ok_o   (wide_ok)
  );
`else
  logic unused_wide_inputs;
  assign unused_wide_inputs = ^{req_wide, req_a_hi, req_b_hi};
`endif

  assign req_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept     = req_valid && req_ready;
  assign alu_opcode = alu_opcode_q;
  assign alu_rd     = alu_rd_q;
  assign alu_rr     = alu_rr_q;
  assign alu_ci     = alu_ci_q;
  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign sreg       = sreg_q;

  // Sequencer FSM with registered ALU drive, writeback and status outputs.
  // ALU inputs default to NOP every cycle and are only overridden on the
  // edge that enters an ISSUE state, so they are live for exactly that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mult_q       <= 1'b0;
      rd_q         <= '0;
      alu_opcode_q <= OP_NOP;
      alu_rd_q     <= 8'h00;
      alu_rr_q     <= 8'h00;
      alu_ci_q     <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= 16'h0000;
      sreg_q       <= 3'b000;
`ifdef ALU_CTRL_WIDE_EN
      wide_q       <= 1'b0;
      hi_op_q      <= 8'h00;
      a_hi_q       <= 8'h00;
      b_hi_q       <= 8'h00;
      lo_q         <= 8'h00;
      lo_z_q       <= 1'b0;
`endif
    end else begin
      alu_opcode_q <= OP_NOP;
      alu_rd_q     <= 8'h00;
      alu_rr_q     <= 8'h00;
      alu_ci_q     <= 1'b0;
      wb_valid_q   <= 1'b0;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            mult_q       <= (req_opcode[7:4] == OP_MULT);
            rd_q         <= req_rd;
`ifdef ALU_CTRL_WIDE_EN
            wide_q       <= req_wide && wide_ok;
            hi_op_q      <= hi_op_d;
            a_hi_q       <= req_a_hi;
            b_hi_q       <= req_b_hi;
`endif
            // Low pass chains from the current carry flag.
            alu_opcode_q <= req_opcode;
            alu_rd_q     <= req_a;
            alu_rr_q     <= req_b;
            alu_ci_q     <= sreg_q[SREG_C];
            state_q      <= ST_ISSUE_LO;
          end else begin
            state_q      <= ST_IDLE;
          end
        end

        ST_ISSUE_LO: begin
          cnt_q   <= CNT_INIT;
          state_q <= SKIP_WAIT ? ST_CAP_LO : ST_WAIT_LO;
        end

        ST_WAIT_LO: begin
          if (cnt_q == '0) state_q <= ST_CAP_LO;
          else             cnt_q   <= cnt_q - 1'b1;
        end

        ST_CAP_LO: begin
`ifdef ALU_CTRL_WIDE_EN
          if (wide_q) begin
            // Keep the low byte and its zero flag; its carry feeds the high pass.
            lo_q         <= alu_data[7:0];
            lo_z_q       <= alu_zo;
            alu_opcode_q <= hi_op_q;
            alu_rd_q     <= a_hi_q;
            alu_rr_q     <= b_hi_q;
            alu_ci_q     <= alu_co;
            state_q      <= ST_ISSUE_HI;
          end else
`endif
          begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= rd_q;
            wb_data_q  <= mult_q ? alu_data : {8'h00, alu_data[7:0]};
            sreg_q     <= {alu_no, alu_zo, alu_co};
            state_q    <= ST_DONE;
          end
        end

`ifdef ALU_CTRL_WIDE_EN
        ST_ISSUE_HI: begin
          cnt_q   <= CNT_INIT;
          state_q <= SKIP_WAIT ? ST_CAP_HI : ST_WAIT_HI;
        end

        ST_WAIT_HI: begin
          if (cnt_q == '0) state_q <= ST_CAP_HI;
          else             cnt_q   <= cnt_q - 1'b1;
        end

        ST_CAP_HI: begin
          wb_valid_q <= 1'b1;
          wb_addr_q  <= rd_q;
          wb_data_q  <= {alu_data[7:0], lo_q};
          sreg_q     <= {alu_no, lo_z_q & alu_zo, alu_co};
          state_q    <= ST_DONE;
        end
`endif

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: a behavioural 2-stage ALU sits beside the
// DUT, and expected writebacks come from plain 8/16-bit arithmetic.
// Honours ALU_CTRL_WIDE_EN in the same way as the design.
module tb_alu_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_opcode, req_a, req_b, req_a_hi, req_b_hi;
  logic        req_wide;
  logic [4:0]  req_rd;
  logic [7:0]  alu_opcode, alu_rd, alu_rr;
  logic        alu_ci;
  logic [15:0] alu_data;
  logic        alu_co, alu_zo, alu_no;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  sreg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0]  model_sreg = 3'b000;
  logic [15:0] last_data;
  logic [2:0]  last_sreg;
  logic [4:0]  last_addr;
  int          last_lat;

  always #5 clk = ~clk;

  alu_ctrl #(.ALU_LAT(LAT), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .req_a_hi(req_a_hi), .req_b_hi(req_b_hi),
    .req_wide(req_wide), .req_rd(req_rd),
    .alu_opcode(alu_opcode), .alu_rd(alu_rd), .alu_rr(alu_rr), .alu_ci(alu_ci),
    .alu_data(alu_data), .alu_co(alu_co), .alu_zo(alu_zo), .alu_no(alu_no),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .sreg(sreg)
  );

  // Behavioural ALU: one input stage, one result stage; NOP holds everything.
  // The upper data byte of 8-bit ops is deliberately junk.
  function automatic logic [18:0] alu_fn(input logic [7:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
    logic [8:0]  s;
    logic [15:0] p;
    case (op[7:4])
      4'h0: s = {1'b0, a & b};
      4'h1: s = {1'b0, a | b};
      4'h2: s = {1'b0, a ^ b};
      4'h3: begin
        p = {8'h00, a} * {8'h00, b};
        return {p[15], (p == 16'h0000), 1'b0, p};
      end
      4'h4: s = {1'b0, a} + {1'b0, b};
      4'h5: s = {1'b0, a} + {1'b0, b} + {8'h00, ci};
      4'h6: s = {1'b0, a} - {1'b0, b};
      4'h7: s = {1'b0, a} - {1'b0, b} - {8'h00, ci};
      4'h8: s = {1'b0, a} + 9'd1;
      4'h9: s = {1'b0, a} - 9'd1;
      4'hA: s = 9'd0 - {1'b0, a};
      default: s = {1'b0, a};
    endcase
    return {s[7], (s[7:0] == 8'h00), s[8], a ^ 8'hA5, s[7:0]};
  endfunction

  logic [7:0] s_op, s_a, s_b;
  logic       s_ci;
  always @(posedge clk) begin
    if (rst) begin
      s_op <= 8'hFF; s_a <= 8'h00; s_b <= 8'h00; s_ci <= 1'b0;
      alu_data <= 16'h0000; alu_co <= 1'b0; alu_zo <= 1'b0; alu_no <= 1'b0;
    end else begin
      s_op <= alu_opcode; s_a <= alu_rd; s_b <= alu_rr; s_ci <= alu_ci;
      if (s_op != 8'hFF) {alu_no, alu_zo, alu_co, alu_data} <= alu_fn(s_op, s_a, s_b, s_ci);
    end
  end

  // Reference: whole-operand arithmetic at 8 or 16 bits, returns {n,z,c,data}.
  function automatic logic [18:0] ref_op(input logic [7:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic wide, input logic ci);
    logic [31:0] av, bv, cv, r, mask;
    logic        c;
    int          w;
    w    = wide ? 16 : 8;
    mask = wide ? 32'h0000_FFFF : 32'h0000_00FF;
    av   = {16'h0000, a} & mask;
    bv   = {16'h0000, b} & mask;
    cv   = {31'b0, ci};
    c    = 1'b0;
    case (op[7:4])
      4'h0: r = av & bv;
      4'h1: r = av | bv;
      4'h2: r = av ^ bv;
      4'h3: begin
        r = av * bv;
        return {r[15], (r[15:0] == 16'h0000), 1'b0, r[15:0]};
      end
      4'h4: begin r = av + bv;      c = (r > mask); end
      4'h5: begin r = av + bv + cv; c = (r > mask); end
      4'h6: begin c = (av < bv);      r = av - bv;      end
      4'h7: begin c = (av < bv + cv); r = av - bv - cv; end
      4'h8: begin r = av + 1;       c = (r > mask); end
      4'h9: begin c = (av == 0);    r = av - 1;     end
      4'hA: begin c = (av != 0);    r = 32'd0 - av; end
      default: r = av;
    endcase
    r = r & mask;
    return {r[w-1], (r == 32'd0), c, r[15:0]};
  endfunction

  function automatic logic wide_eff(input logic [7:0] op, input logic wide);
`ifdef ALU_CTRL_WIDE_EN
    return wide && (op[7:4] inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7});
`else
    return 1'b0 & wide & op[0];
`endif
  endfunction

  function automatic logic [7:0] hi_opcode(input logic [7:0] op);
    if (op[7:4] == 4'h4) return {4'h5, op[3:0]};
    if (op[7:4] == 4'h6) return {4'h7, op[3:0]};
    return op;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the writeback strobe; returns edges counted since accept.
  task automatic wait_wb(input logic we, input logic [7:0] op, input logic [7:0] a_hi,
                         input logic [7:0] b_hi, input logic lo_c, input string tag,
                         output int n);
    n = 0;
    while (wb_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, ".nop_after_issue"}, {24'h0, alu_opcode}, 32'hFF);
      if (we && n == LAT + 1) begin
        check({tag, ".hi_opcode"}, {24'h0, alu_opcode}, {24'h0, hi_opcode(op)});
        check({tag, ".hi_rd"}, {24'h0, alu_rd}, {24'h0, a_hi});
        check({tag, ".hi_rr"}, {24'h0, alu_rr}, {24'h0, b_hi});
        check({tag, ".hi_ci"}, {31'h0, alu_ci}, {31'h0, lo_c});
      end
    end
  endtask

  task automatic run_op(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic wide, input logic [4:0] rd, input string tag);
    logic [18:0] r, lo;
    logic        we;
    int          n;
    we = wide_eff(op, wide);
    r  = ref_op(op, a, b, we, model_sreg[0]);
    lo = ref_op(op, a, b, 1'b0, model_sreg[0]);
    @(negedge clk);
    check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_opcode = op; req_a = a[7:0]; req_b = b[7:0];
    req_a_hi = a[15:8]; req_b_hi = b[15:8]; req_wide = wide; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0;
    req_a = 8'($urandom); req_b = 8'($urandom); req_rd = 5'($urandom);
    req_a_hi = 8'($urandom); req_b_hi = 8'($urandom); req_opcode = 8'($urandom);
    check({tag, ".issue_op"}, {24'h0, alu_opcode}, {24'h0, op});
    check({tag, ".issue_rd"}, {24'h0, alu_rd}, {24'h0, a[7:0]});
    check({tag, ".issue_rr"}, {24'h0, alu_rr}, {24'h0, b[7:0]});
    check({tag, ".issue_ci"}, {31'h0, alu_ci}, {31'h0, model_sreg[0]});
    wait_wb(we, op, a[15:8], b[15:8], lo[16], tag, n);
    check({tag, ".latency"}, n, we ? 2 * LAT + 2 : LAT + 1);
    check({tag, ".wb_data"}, {16'h0, wb_data}, {16'h0, r[15:0]});
    check({tag, ".wb_addr"}, {27'h0, wb_addr}, {27'h0, rd});
    check({tag, ".sreg"}, {29'h0, sreg}, {29'h0, r[18:16]});
    last_data = wb_data; last_sreg = sreg; last_addr = wb_addr; last_lat = n;
    model_sreg = r[18:16];
    @(negedge clk);
    check({tag, ".strobe_1cyc"}, {31'h0, wb_valid}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] r1, r2;
    logic [7:0]  op;
    logic [15:0] a, b;
    int          n;
    logic        seen;

    rst = 1'b1; req_valid = 1'b0; req_opcode = 8'h00; req_a = 8'h00; req_b = 8'h00;
    req_a_hi = 8'h00; req_b_hi = 8'h00; req_wide = 1'b0; req_rd = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst.alu_opcode", {24'h0, alu_opcode}, 32'hFF);
    check("rst.alu_rd", {24'h0, alu_rd}, 32'h0);
    check("rst.alu_rr", {24'h0, alu_rr}, 32'h0);
    check("rst.alu_ci", {31'h0, alu_ci}, 32'h0);
    check("rst.wb_valid", {31'h0, wb_valid}, 32'h0);
    check("rst.wb_data", {16'h0, wb_data}, 32'h0);
    check("rst.wb_addr", {27'h0, wb_addr}, 32'h0);
    check("rst.sreg", {29'h0, sreg}, 32'h0);
    check("rst.ready", {31'h0, req_ready}, 32'h1);

    // Narrow ADD 0x7F + 0x01 -> 0x0080, n set
    run_op(8'h40, 16'h007F, 16'h0001, 1'b0, 5'd3, "add_narrow");
    check("add_narrow.lit_data", {16'h0, last_data}, 32'h0080);
    check("add_narrow.lit_sreg", {29'h0, last_sreg}, 32'b100);
    check("add_narrow.lit_addr", {27'h0, last_addr}, 32'd3);
    check("add_narrow.lit_lat", last_lat, 32'd3);

    // Narrow MULT keeps the full 16-bit product
    run_op(8'h30, 16'h0010, 16'h0020, 1'b0, 5'd7, "mult");
    check("mult.lit_data", {16'h0, last_data}, 32'h0200);
    check("mult.lit_zc", {30'h0, last_sreg[1:0]}, 32'b00);

    // Wide ADD 0x12FF + 0x0001
    run_op(8'h40, 16'h12FF, 16'h0001, 1'b1, 5'd9, "add_wide");
`ifdef ALU_CTRL_WIDE_EN
    check("add_wide.lit_data", {16'h0, last_data}, 32'h1300);
    check("add_wide.lit_sreg", {29'h0, last_sreg}, 32'b000);
    check("add_wide.lit_lat", last_lat, 32'd6);
`else
    check("add_wide.lit_data", {16'h0, last_data}, 32'h0000);
    check("add_wide.lit_c", {31'h0, last_sreg[0]}, 32'h1);
    check("add_wide.lit_lat", last_lat, 32'd3);
`endif

    // Back-to-back ADDs with req_valid held high; second sees first's carry
    r1 = ref_op(8'h40, 16'h00FF, 16'h0001, 1'b0, model_sreg[0]);
    r2 = ref_op(8'h40, 16'h0010, 16'h0020, 1'b0, r1[16]);
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 8'h40; req_a = 8'hFF; req_b = 8'h01; req_wide = 1'b0; req_rd = 5'd4;
    @(negedge clk);
    check("b2b.first_ci", {31'h0, alu_ci}, {31'h0, model_sreg[0]});
    req_a = 8'h10; req_b = 8'h20; req_rd = 5'd5;
    wait_wb(1'b0, 8'h40, 8'h00, 8'h00, 1'b0, "b2b1", n);
    check("b2b.first_lat", n, LAT + 1);
    check("b2b.first_data", {16'h0, wb_data}, {16'h0, r1[15:0]});
    check("b2b.first_sreg", {29'h0, sreg}, {29'h0, r1[18:16]});
    check("b2b.ready_in_done", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b.second_issue_op", {24'h0, alu_opcode}, 32'h40);
    check("b2b.second_issue_rd", {24'h0, alu_rd}, 32'h10);
    check("b2b.second_ci", {31'h0, alu_ci}, {31'h0, r1[16]});
    check("b2b.second_ci_lit", {31'h0, alu_ci}, 32'h1);
    check("b2b.busy", {31'h0, req_ready}, 32'h0);
    check("b2b.strobe_drop", {31'h0, wb_valid}, 32'h0);
    wait_wb(1'b0, 8'h40, 8'h00, 8'h00, 1'b0, "b2b2", n);
    check("b2b.second_lat", n, LAT + 1);
    check("b2b.second_data", {16'h0, wb_data}, {16'h0, r2[15:0]});
    check("b2b.second_addr", {27'h0, wb_addr}, 32'd5);
    check("b2b.second_sreg", {29'h0, sreg}, {29'h0, r2[18:16]});
    model_sreg = r2[18:16];
    @(negedge clk);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      op = {4'($urandom_range(0, 10)), 4'($urandom_range(0, 15))};
      a  = 16'($urandom);
      b  = 16'($urandom);
      run_op(op, a, b, 1'($urandom), 5'($urandom), $sformatf("rnd%0d", i));
    end

    // Reset in the middle of an op: no writeback, everything cleared
    run_op(8'h40, 16'h007F, 16'h0001, 1'b0, 5'd3, "pre_rst");
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 8'h40; req_a = 8'hFF; req_b = 8'h01;
    req_a_hi = 8'h12; req_b_hi = 8'h00; req_wide = 1'b1; req_rd = 5'd6;
    @(negedge clk);
    req_valid = 1'b0;
`ifdef ALU_CTRL_WIDE_EN
    repeat (2 * LAT) @(negedge clk);
`else
    repeat (1) @(negedge clk);
`endif
    check("midrst.no_wb_yet", {31'h0, wb_valid}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.ready", {31'h0, req_ready}, 32'h1);
    check("midrst.alu_opcode", {24'h0, alu_opcode}, 32'hFF);
    check("midrst.sreg", {29'h0, sreg}, 32'h0);
    check("midrst.wb_data", {16'h0, wb_data}, 32'h0);
    check("midrst.wb_addr", {27'h0, wb_addr}, 32'h0);
    seen = wb_valid;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen = seen | wb_valid;
    end
    check("midrst.no_wb", {31'h0, seen}, 32'h0);
    model_sreg = 3'b000;

    // Operation after reset behaves normally and uses the cleared carry
    run_op(8'h50, 16'h0001, 16'h0002, 1'b0, 5'd1, "post_rst_addc");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
